// File: rtl/video_interlacer.sv
// Progressive-to-interlaced Avalon-ST video converter. Keeps only the lines of the current field,
// rewrites control packets with per-field line counts and alternates the field after each video packet.
module video_interlacer #(
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  localparam int DATA_WIDTH      = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  field,
  output logic                  err_short,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CTRL_RX = 3'd1;
  localparam logic [2:0] S_CTRL_TX = 3'd2;
  localparam logic [2:0] S_VIDEO   = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_PASS    = 3'd5;

  logic [2:0]            state;
  logic [15:0]           w, h, col, row, lines;
  logic [2:0]            rx_cnt;
  logic [1:0]            tx_cnt;
  logic                  out_free, accept, kept_row, last_kept;
  logic [DATA_WIDTH-1:0] tx_data;

  // Handshake: a beat moves on either port when valid and ready are both high in the same cycle;
  // the output register may only be reloaded when it is empty or being emptied this cycle.
  assign out_free  = !dout_valid || dout_ready;
  assign accept    = din_valid && din_ready;
  assign lines     = 16'(({1'b0, h} + {16'b0, ~field}) >> 1);
  assign kept_row  = (row[0] == field);
  // Within a kept row, row>>1 is the line index inside the field.
  assign last_kept = kept_row && (col == w - 16'd1) && ((row >> 1) == lines - 16'd1);
  assign dbg_state = state;

  always_comb begin
    din_ready = 1'b0;
    if (reset) begin
      case (state)
        S_IDLE, S_PASS:     din_ready = out_free;
        S_CTRL_RX, S_DRAIN: din_ready = 1'b1;
        // Dropped lines drain freely unless they end the packet and must emit a terminator.
        S_VIDEO:            din_ready = (kept_row || din_endofpacket) ? out_free : 1'b1;
        default:            din_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (tx_cnt)
      2'd0:    tx_data = 24'h00000F;
      2'd1:    tx_data = {4'h0, w[7:4], 4'h0, w[11:8], 4'h0, w[15:12]};
      2'd2:    tx_data = {4'h0, lines[11:8], 4'h0, lines[15:12], 4'h0, w[3:0]};
      default: tx_data = {4'h0, (field ? 4'hC : 4'h8), 4'h0, lines[3:0], 4'h0, lines[7:4]};
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= S_IDLE;
      dout_data          <= '0;
      dout_valid         <= 1'b0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
      field              <= 1'b0;
      err_short          <= 1'b0;
      col                <= '0;
      row                <= '0;
      rx_cnt             <= '0;
      tx_cnt             <= '0;
      w                  <= 16'(WIDTH);
      h                  <= 16'(HEIGHT);
    end else begin
      err_short <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && din_startofpacket) begin
            if (din_data[3:0] == 4'hF) begin
              rx_cnt <= 3'd1;
              tx_cnt <= 2'd0;
              state  <= din_endofpacket ? S_CTRL_TX : S_CTRL_RX;
            end else if (din_data[3:0] == 4'h0) begin
              dout_valid         <= 1'b1;
              dout_data          <= din_data;
              dout_startofpacket <= 1'b1;
              col                <= '0;
              row                <= '0;
              if (lines == 16'd0 || w == 16'd0) begin
                dout_endofpacket <= 1'b1;
                if (din_endofpacket) field <= ~field;
                state <= din_endofpacket ? S_IDLE : S_DRAIN;
              end else begin
                dout_endofpacket <= 1'b0;
                state            <= S_VIDEO;
              end
            end else begin
              dout_valid         <= 1'b1;
              dout_data          <= din_data;
              dout_startofpacket <= 1'b1;
              dout_endofpacket   <= din_endofpacket;
              state              <= din_endofpacket ? S_IDLE : S_PASS;
            end
          end
        end
        S_PASS: begin
          if (accept) begin
            dout_valid         <= 1'b1;
            dout_data          <= din_data;
            dout_startofpacket <= din_startofpacket;
            dout_endofpacket   <= din_endofpacket;
            if (din_endofpacket) state <= S_IDLE;
          end
        end
        S_CTRL_RX: begin
          if (accept) begin
            case (rx_cnt)
              3'd1: w[15:4] <= {din_data[3:0], din_data[11:8], din_data[19:16]};
              3'd2: begin
                w[3:0]  <= din_data[3:0];
                h[15:8] <= {din_data[11:8], din_data[19:16]};
              end
              3'd3: h[7:0] <= {din_data[3:0], din_data[11:8]};
              default: ;
            endcase
            if (rx_cnt != 3'd4) rx_cnt <= rx_cnt + 3'd1;
            if (din_endofpacket) begin
              tx_cnt <= 2'd0;
              state  <= S_CTRL_TX;
            end
          end
        end
        S_CTRL_TX: begin
          if (out_free) begin
            dout_valid         <= 1'b1;
            dout_data          <= tx_data;
            dout_startofpacket <= (tx_cnt == 2'd0);
            dout_endofpacket   <= (tx_cnt == 2'd3);
            tx_cnt             <= tx_cnt + 2'd1;
            if (tx_cnt == 2'd3) state <= S_IDLE;
          end
        end
        S_VIDEO: begin
          if (accept) begin
            if (col == w - 16'd1) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
            if (kept_row) begin
              dout_valid         <= 1'b1;
              dout_data          <= din_data;
              dout_startofpacket <= 1'b0;
              dout_endofpacket   <= last_kept || din_endofpacket;
              if (last_kept && !din_endofpacket) begin
                state <= S_DRAIN;
              end else if (last_kept || din_endofpacket) begin
                state <= S_IDLE;
                field <= ~field;
              end
            end else if (din_endofpacket) begin
              // Input ended on a discarded line: close the output packet with a blank beat.
              dout_valid         <= 1'b1;
              dout_data          <= '0;
              dout_startofpacket <= 1'b0;
              dout_endofpacket   <= 1'b1;
              err_short          <= 1'b1;
              state              <= S_IDLE;
              field              <= ~field;
            end
          end
        end
        S_DRAIN: begin
          if (accept && din_endofpacket) begin
            state <= S_IDLE;
            field <= ~field;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_interlacer.sv
// Self-checking bench for video_interlacer: packet-level reference model feeding an expected-beat queue,
// a table of frame scenarios, randomized frames with output backpressure, and reset/drain corner cases.
module tb_video_interlacer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] din_data = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        din_startofpacket = 1'b0;
  logic        din_endofpacket = 1'b0;
  logic [23:0] dout_data;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_startofpacket;
  logic        dout_endofpacket;
  logic        field;
  logic        err_short;
  logic [2:0]  dbg_state;

  video_interlacer #(.WIDTH(4), .HEIGHT(3)) dut (
    .clock(clock), .reset(reset),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .field(field), .err_short(err_short), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [25:0] exp_q[$];            // {sop, eop, data}
  logic [23:0] pix_q[$];
  int          m_w = 4;
  int          m_h = 3;
  bit          m_field = 1'b0;
  int          exp_err = 0;
  int          err_seen = 0;
  int          out_cnt = 0;
  bit          check_en = 1'b0;
  bit          rand_ready = 1'b0;
  bit          stall_force = 1'b0;

  typedef struct {
    int w; int h; int npix; int nout; int nerr; bit fld;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- output sink / monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      dout_ready = stall_force ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  initial begin
    logic [25:0] got, prev_beat, exp;
    bit prev_stall, prev_err;
    prev_stall = 0; prev_err = 0; prev_beat = '0;
    forever begin
      @(negedge clock); #2;
      if (!reset) begin
        prev_stall = 0; prev_err = 0;
      end else begin
        got = {dout_startofpacket, dout_endofpacket, dout_data};
        if (prev_stall) begin
          n_cmp++;
          if (!dout_valid || got !== prev_beat) begin
            n_err++;
            $display("FAIL stall_hold: got valid=%0b beat=%0h required valid=1 beat=%0h", dout_valid, got, prev_beat);
          end
        end
        if (err_short) begin
          err_seen++;
          if (prev_err) begin
            n_cmp++; n_err++;
            $display("FAIL err_width: err_short high %0d cycles, required 1", 2);
          end
        end
        prev_err = err_short;
        if (dout_valid && dout_ready) begin
          out_cnt++;
          if (check_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_beat: got %0h required no beat", got);
            end else begin
              exp = exp_q.pop_front();
              if (got !== exp) begin
                n_err++;
                $display("FAIL out_beat: got {sop,eop,data}=%0h required %0h", got, exp);
              end
            end
          end
        end
        prev_stall = dout_valid && !dout_ready;
        prev_beat  = got;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [23:0] d, input bit sop, input bit eop, output int waited);
    waited = 0;
    @(negedge clock);
    din_data = d; din_startofpacket = sop; din_endofpacket = eop; din_valid = 1'b1;
    #1;
    while (din_ready !== 1'b1 && waited < 300) begin
      @(negedge clock); #1;
      waited++;
    end
    if (din_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL din_ready_timeout: waited %0d cycles, required accept", waited);
    end
    @(posedge clock); #1;
    din_valid = 1'b0; din_startofpacket = 1'b0; din_endofpacket = 1'b0;
  endtask

  task automatic model_ctrl(input int w, input int h);
    logic [15:0] wv, hv, lv;
    int wt;
    m_w = w; m_h = h;
    wv = 16'(w); hv = 16'(h);
    lv = 16'(m_field ? h / 2 : (h + 1) / 2);
    exp_q.push_back({2'b10, 24'h00000F});
    exp_q.push_back({2'b00, 4'h0, wv[7:4], 4'h0, wv[11:8], 4'h0, wv[15:12]});
    exp_q.push_back({2'b00, 4'h0, lv[11:8], 4'h0, lv[15:12], 4'h0, wv[3:0]});
    exp_q.push_back({2'b01, 4'h0, (m_field ? 4'hC : 4'h8), 4'h0, lv[3:0], 4'h0, lv[7:4]});
    drive(24'h00000F, 1, 0, wt);
    drive({4'h0, wv[7:4], 4'h0, wv[11:8], 4'h0, wv[15:12]}, 0, 0, wt);
    drive({4'h0, hv[11:8], 4'h0, hv[15:12], 4'h0, wv[3:0]}, 0, 0, wt);
    drive({12'h000, hv[3:0], 4'h0, hv[7:4]}, 0, 1, wt);
  endtask

  // Reference: walk the input pixels as a raster, keep lines of the current parity until the field's
  // line quota is met or the input ends.
  task automatic model_video(input logic [23:0] hdr);
    int L, r, c;
    bit kept, last, inlast;
    L = m_field ? m_h / 2 : (m_h + 1) / 2;
    if (L == 0 || m_w == 0) begin
      exp_q.push_back({2'b11, hdr});
    end else begin
      exp_q.push_back({2'b10, hdr});
      for (int k = 0; k < pix_q.size(); k++) begin
        r = k / m_w; c = k % m_w;
        inlast = (k == pix_q.size() - 1);
        kept = ((r % 2) == int'(m_field));
        if (kept) begin
          last = (c == m_w - 1) && (r / 2 == L - 1);
          exp_q.push_back({1'b0, last || inlast, pix_q[k]});
          if (last || inlast) break;
        end else if (inlast) begin
          exp_q.push_back({2'b01, 24'h0});
          exp_err++;
        end
      end
    end
    m_field = !m_field;
  endtask

  task automatic send_video(input int npix, input bit rnd);
    logic [23:0] hdr;
    int wt;
    pix_q.delete();
    for (int k = 0; k < npix; k++) pix_q.push_back(rnd ? 24'($urandom) : 24'(k));
    hdr = rnd ? {20'($urandom), 4'h0} : 24'h0;
    model_video(hdr);
    drive(hdr, 1, 0, wt);
    for (int k = 0; k < npix; k++) drive(pix_q[k], 0, k == npix - 1, wt);
  endtask

  task automatic send_pass(input int n);
    logic [23:0] d;
    int wt;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? {20'($urandom), 4'h3} : 24'($urandom);
      exp_q.push_back({k == 0, k == n - 1, d});
      drive(d, k == 0, k == n - 1, wt);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || dout_valid) && t < 500) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock); #3;
    chk({name, "_drain_left"}, exp_q.size(), 0);
    chk({name, "_field"}, field, m_field);
    chk({name, "_err_count"}, err_seen, exp_err);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_dout_valid"}, dout_valid, 0);
    chk({name, "_dout_sop"}, dout_startofpacket, 0);
    chk({name, "_dout_eop"}, dout_endofpacket, 0);
    chk({name, "_dout_data"}, dout_data, 0);
    chk({name, "_din_ready"}, din_ready, 0);
    chk({name, "_field"}, field, 0);
    chk({name, "_err_short"}, err_short, 0);
    chk({name, "_state"}, dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int o0, e0, wt, w, h, np;
    tbl[0] = '{4, 4, 16, 9, 0, 1'b1};
    tbl[1] = '{4, 4, 16, 9, 0, 1'b0};
    tbl[2] = '{2, 5, 10, 7, 0, 1'b1};
    tbl[3] = '{2, 5, 10, 5, 0, 1'b0};
    tbl[4] = '{4, 4,  8, 6, 1, 1'b1};
    tbl[5] = '{4, 4,  6, 3, 0, 1'b0};
    tbl[6] = '{3, 1,  3, 4, 0, 1'b1};
    tbl[7] = '{3, 1,  3, 1, 0, 1'b0};

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #2 check_reset_outputs("reset");
    @(negedge clock); #3 reset = 1'b1;
    check_en = 1'b1;

    // Default geometry 4x3 before any control packet, with a pass-through in between.
    send_video(12, 0);
    wait_drain("default_f0");
    send_pass(3);
    wait_drain("pass");
    send_video(12, 0);
    wait_drain("default_f1");

    for (int i = 0; i < 8; i++) begin
      model_ctrl(tbl[i].w, tbl[i].h);
      wait_drain($sformatf("tbl%0d_ctrl", i));
      o0 = out_cnt; e0 = err_seen;
      send_video(tbl[i].npix, 0);
      wait_drain($sformatf("tbl%0d_video", i));
      chk($sformatf("tbl%0d_nout", i), out_cnt - o0, tbl[i].nout);
      chk($sformatf("tbl%0d_nerr", i), err_seen - e0, tbl[i].nerr);
      chk($sformatf("tbl%0d_fld", i), field, tbl[i].fld);
    end

    // Random geometry, random truncation and random output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(0, 7);
      np = (h == 0) ? $urandom_range(1, 4) : $urandom_range(1, w * h);
      model_ctrl(w, h);
      send_video(np, 1);
      if ($urandom_range(0, 3) == 0) send_pass($urandom_range(2, 4));
      wait_drain($sformatf("rand%0d", i));
    end
    rand_ready = 1'b0;

    // Dropped line keeps draining at one beat per cycle while the output is stalled.
    if (m_field == 1'b0) begin
      model_ctrl(4, 4);
      send_video(16, 1);
      wait_drain("pre_stall");
    end
    model_ctrl(4, 4);
    wait_drain("stall_ctrl");
    pix_q.delete();
    for (int k = 0; k < 16; k++) pix_q.push_back(24'($urandom));
    model_video(24'h0);
    drive(24'h0, 1, 0, wt);
    stall_force = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(pix_q[k], 0, 0, wt);
      chk($sformatf("drop_rate%0d", k), wt, 0);
    end
    stall_force = 1'b0;
    for (int k = 4; k < 16; k++) drive(pix_q[k], 0, k == 15, wt);
    wait_drain("stall_video");

    // Reset in the middle of row 2, then restart from a fresh control packet.
    check_en = 1'b0;
    model_ctrl(4, 4);
    drive(24'h0, 1, 0, wt);
    for (int k = 0; k < 10; k++) drive(24'(k), 0, 0, wt);
    @(negedge clock); #3 reset = 1'b0;
    @(negedge clock); #2 check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    #3 reset = 1'b1;
    exp_q.delete();
    m_field = 1'b0; m_w = 4; m_h = 3;
    exp_err = err_seen;
    check_en = 1'b1;
    for (int k = 0; k < 6; k++) drive(24'h123450 + 24'(k), 0, k == 5, wt);
    model_ctrl(2, 3);
    o0 = out_cnt;
    send_video(6, 1);
    wait_drain("after_reset");
    chk("after_reset_nout", out_cnt - o0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
